// File: rtl/if_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: fetch entry payload,
// prefetch FSM states and word-alignment helper.
package if_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        PF_FETCH = 1'b0,
        PF_DRAIN = 1'b1
    } pf_state_e;

    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with combinational head read, flush, and entry count.
// Push on full is legal only together with a pop.
module sync_fifo
    import if_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Explicit wrap keeps non-power-of-two depths (tag FIFO) correct.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding IF/ID: owns the fetch PC, issues imem
// requests under a credit rule, buffers {pc, instr} and flushes on redirect.
// Optional IF_PREFETCH_BYPASS_EN: zero-latency response bypass when empty.
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [63:0] RESET_PC  = 64'h0,
    localparam int unsigned OCC_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    output logic             imem_req,
    output logic [63:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             out_valid,
    output logic [31:0]      out_instr,
    output logic [63:0]      out_pc,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    localparam int unsigned OUT_W   = $clog2(MAX_OUTST + 1);
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);
    localparam logic [0:0] ST_FETCH = PF_FETCH;
    localparam logic [0:0] ST_DRAIN = PF_DRAIN;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [63:0]      fetch_pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outst_nxt;
    logic [OUT_W-1:0] drop;
    logic [OUT_W-1:0] drop_nxt;

    logic credit_ok;
    logic granted;
    logic resp_any;
    logic resp_take;
    logic bypass;
    logic fire;
    logic entry_push;
    logic entry_pop;
    logic entry_empty;
    logic entry_full;

    fetch_entry_t head;
    fetch_entry_t resp_entry;
    fetch_entry_t out_entry;
    fetch_entry_t last_entry;

    logic [63:0]      tag_pc;
    logic [OUT_W-1:0] tag_count;
    logic             tag_full;
    logic             tag_empty;
    logic             unused_bits;

    // Credit rule: every request in flight already owns a FIFO slot.
    assign credit_ok = (32'(outstanding) < MAX_OUTST) &&
                       (32'(occupancy) + 32'(outstanding) < DEPTH);

    assign imem_req  = !rst && !redirect_valid && (state == ST_FETCH) && credit_ok;
    assign imem_addr = fetch_pc;
    assign granted   = imem_req && imem_gnt;

    // Responses with nothing in flight (e.g. after reset) are ignored.
    assign resp_any  = imem_rvalid && (outstanding != '0);
    assign resp_take = resp_any && (state == ST_FETCH) && !redirect_valid;
    assign resp_entry = '{pc: tag_pc, instr: imem_rdata};

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass = resp_take && entry_empty && out_ready;
`else
    assign bypass = 1'b0;
`endif

    // Hold the last delivered entry on out_* while the queue is empty.
    assign out_entry  = bypass ? resp_entry : (entry_empty ? last_entry : head);
    assign out_valid  = !rst && !redirect_valid && (!entry_empty || bypass);
    assign out_pc     = out_entry.pc;
    assign out_instr  = out_entry.instr;
    assign fire       = out_valid && out_ready;
    assign entry_pop  = fire && !bypass;
    assign entry_push = resp_take && !bypass;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (redirect_valid),
        .push    (entry_push),
        .wr_data (resp_entry),
        .pop     (entry_pop),
        .rd_data (head),
        .count   (occupancy),
        .full    (entry_full),
        .empty   (entry_empty)
    );

    // Address of each granted request, consumed in response order.
    sync_fifo #(
        .WIDTH (64),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (redirect_valid),
        .push    (granted),
        .wr_data (fetch_pc),
        .pop     (resp_take),
        .rd_data (tag_pc),
        .count   (tag_count),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    assign unused_bits = ^{tag_count, tag_full, tag_empty, entry_full, redirect_pc[1:0]};

    // Next state and in-flight bookkeeping; drop mirrors stale requests.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        outst_nxt = outstanding + OUT_W'(granted) - OUT_W'(resp_any);
        if (redirect_valid) begin
            drop_nxt  = outst_nxt;
            state_nxt = (outst_nxt != '0) ? ST_DRAIN : ST_FETCH;
        end else if (state == ST_DRAIN) begin
            if (resp_any) drop_nxt = drop - OUT_W'(1);
            if (drop_nxt == '0) state_nxt = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            last_entry  <= '0;
        end else begin
            outstanding <= outst_nxt;
            drop        <= drop_nxt;
            if (redirect_valid)   fetch_pc <= word_align(redirect_pc);
            else if (granted)     fetch_pc <= fetch_pc + 64'(INSTR_BYTES);
            if (fire)             last_entry <= out_entry;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_prefetch_queue;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_OUTST = 2;
    localparam logic [63:0] RESET_PC  = 64'h0;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic [2:0]  occupancy;

    if_prefetch_queue #(
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; }            mem_req_t;
    typedef struct { logic [63:0] addr; bit stale; }          flight_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; }   ent_t;
    typedef struct {
        bit redir; logic [63:0] rpc; bit rdy;
        bit ev; logic [63:0] epc; int eocc; bit ereq; logic [63:0] eaddr;
    } vec_t;

    mem_req_t    mem_q[$];
    flight_t     m_if[$];
    ent_t        m_fifo[$];
    ent_t        m_last;
    logic [63:0] m_pc;

    int          checks;
    int          errors;
    int          cyc;
    int unsigned gnt_pct;
    int unsigned lat_lo;
    int unsigned lat_hi;
    bit          force_gnt;

    logic        s_req;
    logic        s_valid;
    logic [63:0] s_addr;
    logic [63:0] s_pc;
    logic [31:0] s_instr;
    logic [2:0]  s_occ;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic set_mem(input int unsigned pct, input int unsigned lo, input int unsigned hi);
        gnt_pct = pct;
        lat_lo  = lo;
        lat_hi  = hi;
    endtask

    // One clock: drive inputs, let the memory respond, check against the model, advance.
    task automatic step(input bit do_rst, input bit redir, input logic [63:0] rpc, input bit rdy);
        bit      drain;
        bit      exp_req;
        bit      exp_valid;
        bit      bypass;
        bit      granted;
        ent_t    exp_e;
        flight_t f;
        rst            = do_rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr[31:0] ^ 32'hA5A5;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        imem_gnt = force_gnt || (imem_req && ($urandom_range(99) < gnt_pct));
        #1;
        granted = imem_req && imem_gnt;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = out_valid;
        s_pc    = out_pc;
        s_instr = out_instr;
        s_occ   = occupancy;

        drain = 1'b0;
        foreach (m_if[i]) if (m_if[i].stale) drain = 1'b1;
        exp_req = !do_rst && !redir && !drain && (m_if.size() < MAX_OUTST) &&
                  (m_fifo.size() + m_if.size() < DEPTH);
        bypass = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass = !do_rst && !redir && !drain && imem_rvalid && rdy &&
                 (m_fifo.size() == 0) && (m_if.size() > 0);
`endif
        exp_valid = !do_rst && !redir && ((m_fifo.size() > 0) || bypass);
        if (bypass)                exp_e = '{m_if[0].addr, imem_rdata};
        else if (m_fifo.size() > 0) exp_e = m_fifo[0];
        else                       exp_e = m_last;

        chk("imem_req", 64'(imem_req), 64'(exp_req));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (!do_rst) begin
            chk("occupancy", 64'(occupancy), 64'(m_fifo.size()));
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            chk("out_pc", out_pc, exp_e.pc);
            chk("out_instr", 64'(out_instr), 64'(exp_e.instr));
        end

        if (do_rst) begin
            m_if.delete();
            m_fifo.delete();
            mem_q.delete();
            m_last = '{64'h0, 32'h0};
            m_pc   = RESET_PC;
        end else begin
            if (exp_valid && rdy) begin
                m_last = exp_e;
                if (!bypass) void'(m_fifo.pop_front());
            end
            if (imem_rvalid && m_if.size() > 0) begin
                f = m_if.pop_front();
                if (!f.stale && !redir && !bypass) m_fifo.push_back('{f.addr, imem_rdata});
            end
            if (granted) begin
                m_if.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 64'd4;
            end
            if (redir) begin
                foreach (m_if[i]) m_if[i].stale = 1'b1;
                m_fifo.delete();
                m_pc = {rpc[63:2], 2'b00};
            end
            if (imem_rvalid) void'(mem_q.pop_front());
            if (granted) mem_q.push_back('{imem_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_req(input int max, output int n);
        n = 0;
        for (int i = 0; i < max; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b1);
            if (s_req) return;
            n++;
        end
        chk("req_timeout", 64'(n), 64'(max + 1));
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b1);
            if (s_valid) return;
        end
        chk("valid_timeout", 64'(s_valid), 64'd1);
    endtask

    vec_t tbl[16];
    int   n;
    bit   redir;
    logic [63:0] rpc;

    initial begin
        checks = 0; errors = 0; cyc = 0; force_gnt = 1'b0;
        set_mem(100, 1, 1);
        m_last = '{64'h0, 32'h0};
        m_pc   = RESET_PC;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // gnt always, rvalid one cycle after gnt; row k = k-th cycle after reset release
        tbl[0]  = '{0, 64'h0,   1, 0, 64'h0,  0, 1, 64'h0};
        tbl[1]  = '{0, 64'h0,   1, 0, 64'h0,  0, 1, 64'h4};
        tbl[2]  = '{0, 64'h0,   1, 1, 64'h0,  1, 1, 64'h8};
        tbl[3]  = '{0, 64'h0,   1, 1, 64'h4,  1, 1, 64'hC};
        tbl[4]  = '{0, 64'h0,   0, 1, 64'h8,  1, 1, 64'h10};
        tbl[5]  = '{0, 64'h0,   0, 1, 64'h8,  2, 1, 64'h14};
        tbl[6]  = '{0, 64'h0,   0, 1, 64'h8,  3, 0, 64'h0};
        tbl[7]  = '{0, 64'h0,   0, 1, 64'h8,  4, 0, 64'h0};
        tbl[8]  = '{0, 64'h0,   1, 1, 64'h8,  4, 0, 64'h0};
        tbl[9]  = '{0, 64'h0,   1, 1, 64'hC,  3, 1, 64'h18};
        tbl[10] = '{0, 64'h0,   1, 1, 64'h10, 2, 1, 64'h1C};
        tbl[11] = '{0, 64'h0,   1, 1, 64'h14, 2, 1, 64'h20};
        tbl[12] = '{1, 64'h100, 1, 0, 64'h18, 2, 0, 64'h0};
        tbl[13] = '{0, 64'h0,   1, 0, 64'h14, 0, 1, 64'h100};
        tbl[14] = '{0, 64'h0,   1, 0, 64'h14, 0, 1, 64'h104};
        tbl[15] = '{0, 64'h0,   1, 1, 64'h100,1, 1, 64'h108};

        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);

`ifndef IF_PREFETCH_BYPASS_EN
        foreach (tbl[k]) begin
            step(1'b0, tbl[k].redir, tbl[k].rpc, tbl[k].rdy);
            chk($sformatf("tbl%0d_valid", k), 64'(s_valid), 64'(tbl[k].ev));
            chk($sformatf("tbl%0d_occ", k), 64'(s_occ), 64'(tbl[k].eocc));
            chk($sformatf("tbl%0d_req", k), 64'(s_req), 64'(tbl[k].ereq));
            chk($sformatf("tbl%0d_pc", k), s_pc, tbl[k].epc);
            if (tbl[k].ereq) chk($sformatf("tbl%0d_addr", k), s_addr, tbl[k].eaddr);
            if (tbl[k].ev)   chk($sformatf("tbl%0d_instr", k), 64'(s_instr), 64'(tbl[k].epc[31:0] ^ 32'hA5A5));
        end
`endif

        // Redirect with two requests in flight: both responses discarded.
        set_mem(100, 3, 3);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b1, 64'h100, 1'b1);
        chk("redir_req_off", 64'(s_req), 64'd0);
        run_until_req(10, n);
        chk("drain_cycles", 64'(n), 64'd2);
        chk("refetch_addr", s_addr, 64'h100);
        wait_valid(20);
        chk("first_pc_after_redir", s_pc, 64'h100);

        // Unaligned redirect coinciding with rvalid and gnt.
        set_mem(100, 1, 1);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b1);
        force_gnt = 1'b1;
        step(1'b0, 1'b1, 64'h102, 1'b1);
        force_gnt = 1'b0;
        chk("valid_in_redir", 64'(s_valid), 64'd0);
        run_until_req(10, n);
        chk("no_drain_cycles", 64'(n), 64'd0);
        chk("aligned_refetch", s_addr, 64'h100);
        wait_valid(20);
        chk("aligned_first_pc", s_pc, 64'h100);

        // Second redirect while draining.
        set_mem(100, 4, 4);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b1, 64'h100, 1'b1);
        step(1'b0, 1'b1, 64'h200, 1'b1);
        run_until_req(10, n);
        chk("drain2_cycles", 64'(n), 64'd2);
        chk("drain2_refetch", s_addr, 64'h200);

        // Reset with buffered entries and two in flight.
        set_mem(100, 3, 3);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        n = 0;
        while (!(m_if.size() == 2 && m_fifo.size() > 0) && n < 20) begin
            step(1'b0, 1'b0, 64'h0, 1'b0);
            n++;
        end
        chk("fill_reached", 64'(n < 20), 64'd1);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("post_rst_valid", 64'(s_valid), 64'd0);
        chk("post_rst_occ", 64'(s_occ), 64'd0);
        chk("post_rst_req", 64'(s_req), 64'd1);
        chk("post_rst_addr", s_addr, RESET_PC);

        // Randomized traffic against the reference model.
        set_mem(75, 1, 3);
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) set_mem($urandom_range(100, 30), 1, $urandom_range(4, 1));
            redir = ($urandom_range(29) == 0);
            if ($urandom_range(3) == 0) rpc = {32'hFFFF_FFFF, 32'hFFFF_FFF0 | 32'($urandom_range(15))};
            else                        rpc = {$urandom, $urandom};
            step($urandom_range(249) == 0, redir, rpc, $urandom_range(9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
